// File: rtl/add_sub_pkg.sv
//==============================================================================
// Module      : add_sub_pkg
// Description : Shared types and default width for the add_sub arbiter slice.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package add_sub_pkg;

    localparam int c_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//==============================================================================
// Module      : rr_arb2
// Description : Two-requester combinational round-robin grant.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb2
    import add_sub_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            // On a tie the requester that did not win last time goes first
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase

        grant = 2'b00;
        if (valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_sub_arbiter.sv
//==============================================================================
// Module      : add_sub_arbiter
// Description : Shares one add_sub datapath between two requesters; latches the
//               operands, runs one EXEC cycle, returns a registered response.
//               Optional overflow counter enabled by ADD_SUB_ARBITER_OV_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module add_sub_arbiter
    import add_sub_pkg::*;
#(
    parameter int WIDTH = c_width
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_s,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s,
    input  logic [WIDTH-1:0] alu_total,
    input  logic             alu_carry,
    input  logic             alu_ov,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_total,
    output logic             rsp_carry,
    output logic             rsp_ov,
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
    input  logic             ov_clr,
    output logic [7:0]       ov_count,
`endif
    output logic             busy
);

    state_t     r_state;
    state_t     w_next_state;
    req_id_t    r_last_grant;
    req_id_t    r_id;
    logic [1:0] w_valid;
    logic [1:0] w_grant;
    req_id_t    w_grant_id;
    logic       w_accept;

    assign w_valid = {req1_valid, req0_valid};
    assign busy    = (r_state != IDLE);

    rr_arb2 u_rr_arb2 (
        .valid      (w_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_grant[0];
                req1_ready = w_grant[1];
                w_accept   = |w_grant;
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operands stay on the datapath after an operation; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_total    <= '0;
            rsp_carry    <= 1'b0;
            rsp_ov       <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a        <= w_grant_id ? req1_a : req0_a;
                alu_b        <= w_grant_id ? req1_b : req0_b;
                alu_s        <= w_grant_id ? req1_s : req0_s;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= r_id;
                rsp_total <= alu_total;
                rsp_carry <= alu_carry;
                rsp_ov    <= alu_ov;
            end
            if ((r_state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADD_SUB_ARBITER_OV_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_count <= 8'd0;
        end else if (ov_clr) begin
            ov_count <= 8'd0;
        end else if ((r_state == EXEC) && alu_ov && (ov_count != 8'hFF)) begin
            ov_count <= ov_count + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_sub_arbiter.sv
//==============================================================================
// Module      : tb_add_sub_arbiter
// Description : Self-checking bench for add_sub_arbiter with a behavioural
//               add_sub datapath and a latency-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_add_sub_arbiter;
    import add_sub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req0_ready, req0_s;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_s;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] alu_a, alu_b, alu_total;
    logic         alu_s, alu_carry, alu_ov;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ov, busy;
    logic [W-1:0] rsp_total;
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
    logic         ov_clr;
    logic [7:0]   ov_count;
`endif

    always #5 clk = ~clk;

    add_sub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_s     (req1_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_total  (alu_total),
        .alu_carry  (alu_carry),
        .alu_ov     (alu_ov),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_total  (rsp_total),
        .rsp_carry  (rsp_carry),
        .rsp_ov     (rsp_ov),
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
        .ov_clr     (ov_clr),
        .ov_count   (ov_count),
`endif
        .busy       (busy)
    );

    // Behavioural stand-in for the shared add_sub instance
    logic [W-1:0] w_bx;
    logic [W:0]   w_sum;
    assign w_bx      = alu_b ^ {W{alu_s}};
    assign w_sum     = {1'b0, alu_a} + {1'b0, w_bx} + {{W{1'b0}}, alu_s};
    assign alu_total = w_sum[W-1:0];
    assign alu_carry = w_sum[W];
    assign alu_ov    = (alu_a[W-1] == w_bx[W-1]) && (alu_total[W-1] != alu_a[W-1]);

    typedef struct packed {
        logic         ov;
        logic         c;
        logic [W-1:0] t;
    } res_t;

    typedef struct {
        int id;
        int total;
        int c;
        int ov;
        int rcycle;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   acc_id[$];
    int   acc_cyc[$];
    rsp_t rlog[$];
    bit   obs_acc0, obs_acc1;

    // Reference model state
    bit           m_busy;
    int           m_age;
    bit           m_last;
    bit           m_id;
    logic [W-1:0] m_a, m_b;
    logic         m_s;
    logic         e_id, e_c, e_ov;
    logic [W-1:0] e_total;
    int           m_cnt;

    function automatic res_t ref_op(input int a, input int b, input int s);
        int   sa, sb, r, sr;
        res_t q;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (s == 0) begin
            r    = a + b;
            q.c  = (r >= 16);
            sr   = sa + sb;
        end else begin
            r    = a - b;
            q.c  = (a >= b);
            sr   = sa - sb;
        end
        q.t  = 4'((r + 16) % 16);
        q.ov = (sr > 7) || (sr < -8);
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_last = 1; m_id = 0;
        m_a = '0; m_b = '0; m_s = 1'b0;
        e_id = 1'b0; e_c = 1'b0; e_ov = 1'b0; e_total = '0;
        m_cnt = 0;
    endtask

    // One clock cycle: check outputs against the model, then advance it
    task automatic cyc();
        int           g;
        logic [W-1:0] a0, b0, a1, b1;
        logic         s0, s1, rr;
        bit           clr;
        res_t         q;
        #1;
        g = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) g = m_last ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, m_busy && (m_age >= 1));
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_total", rsp_total, e_total);
        chk("rsp_carry", rsp_carry, e_c);
        chk("rsp_ov", rsp_ov, e_ov);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_s", alu_s, m_s);
        clr = 0;
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
        chk("ov_count", ov_count, m_cnt);
        clr = ov_clr;
`endif
        obs_acc0 = req0_valid && req0_ready;
        obs_acc1 = req1_valid && req1_ready;
        if (obs_acc0) begin acc_id.push_back(0); acc_cyc.push_back(cycle); end
        if (obs_acc1) begin acc_id.push_back(1); acc_cyc.push_back(cycle); end
        if (rsp_valid && rsp_ready)
            rlog.push_back('{int'(rsp_id), int'(rsp_total), int'(rsp_carry), int'(rsp_ov), cycle});
        a0 = req0_a; b0 = req0_b; s0 = req0_s;
        a1 = req1_a; b1 = req1_b; s1 = req1_s;
        rr = rsp_ready;
        @(posedge clk);
        cycle++;
        if (clr) m_cnt = 0;
        if (m_busy) begin
            if (m_age == 0) begin
                q       = ref_op(int'(m_a), int'(m_b), int'(m_s));
                e_total = q.t;
                e_c     = q.c;
                e_ov    = q.ov;
                e_id    = m_id;
                if (!clr && q.ov && m_cnt < 255) m_cnt++;
                m_age = 1;
            end else if (rr) begin
                m_busy = 0;
            end
        end else if (g >= 0) begin
            m_busy = 1; m_age = 0; m_last = (g == 1); m_id = (g == 1);
            m_a = (g == 1) ? a1 : a0;
            m_b = (g == 1) ? b1 : b0;
            m_s = (g == 1) ? s1 : s0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_total", rsp_total, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input int id, input int a, input int b, input int s);
        bit done;
        done = 0;
        if (id == 0) begin
            req0_valid = 1; req0_a = 4'(a); req0_b = 4'(b); req0_s = 1'(s);
        end else begin
            req1_valid = 1; req1_a = 4'(a); req1_b = 4'(b); req1_s = 1'(s);
        end
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = (id == 0) ? obs_acc0 : obs_acc1;
        end
        chk("send_timeout", done, 1);
        if (id == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) cyc();
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_s = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_s = 0;
        rsp_ready  = 1;
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
        ov_clr = 0;
`endif
        do_reset();
        cyc();

        // Single add 5+4
        n = rlog.size(); k = acc_cyc.size();
        send(0, 5, 4, 0);
        wait_idle();
        chk("single_cnt", rlog.size(), n + 1);
        if (rlog.size() > n) begin
            chk("single_id", rlog[n].id, 0);
            chk("single_total", rlog[n].total, 9);
            chk("single_carry", rlog[n].c, 0);
            chk("single_ov", rlog[n].ov, 1);
            chk("single_latency", rlog[n].rcycle - acc_cyc[k], 2);
        end

        // Back-to-back from the same requester
        n = rlog.size(); k = acc_cyc.size();
        send(0, 1, 1, 0);
        send(0, 1, 1, 0);
        wait_idle();
        chk("b2b_cnt", rlog.size(), n + 2);
        if (rlog.size() >= n + 2) begin
            chk("b2b_total0", rlog[n].total, 2);
            chk("b2b_total1", rlog[n+1].total, 2);
            chk("b2b_flags1", {rlog[n+1].c[0], rlog[n+1].ov[0]}, 0);
            chk("b2b_gap", acc_cyc[k+1] - acc_cyc[k], 3);
        end

        // Contention from reset: requester 0 wins the first tie
        do_reset();
        n = rlog.size();
        req0_valid = 1; req0_a = 4'd5; req0_b = 4'd1; req0_s = 1;
        req1_valid = 1; req1_a = 4'd9; req1_b = 4'd8; req1_s = 1;
        for (int i = 0; i < 20 && (req0_valid || req1_valid); i++) begin
            cyc();
            if (obs_acc0) req0_valid = 0;
            if (obs_acc1) req1_valid = 0;
        end
        chk("contend_timeout", {req0_valid, req1_valid}, 0);
        wait_idle();
        if (rlog.size() >= n + 2) begin
            chk("contend_first_id", rlog[n].id, 0);
            chk("contend_first_total", rlog[n].total, 4);
            chk("contend_first_flags", {rlog[n].c[0], rlog[n].ov[0]}, 2'b10);
            chk("contend_second_id", rlog[n+1].id, 1);
            chk("contend_second_total", rlog[n+1].total, 1);
            chk("contend_second_flags", {rlog[n+1].c[0], rlog[n+1].ov[0]}, 2'b10);
        end else begin
            chk("contend_cnt", rlog.size(), n + 2);
        end

        // Both held: grants must alternate
        k = acc_id.size();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 12; i++) cyc();
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        chk("alt_cnt", acc_id.size() - k, 4);
        if (acc_id.size() >= k + 4) begin
            chk("alt_seq", {acc_id[k][0], acc_id[k+1][0], acc_id[k+2][0], acc_id[k+3][0]}, 4'b0101);
        end

        // Backpressure on the response channel
        n = rlog.size();
        rsp_ready = 0;
        send(1, 7, 7, 0);
        req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3; req0_s = 0;
        for (int i = 0; i < 6; i++) cyc();
        chk("bp_busy", busy, 1);
        chk("bp_req0_ready", req0_ready, 0);
        chk("bp_rsp_total", rsp_total, 14);
        rsp_ready = 1;
        cyc();
        chk("bp_release_drop", rsp_valid, 0);
        for (int i = 0; i < 10 && req0_valid; i++) begin
            cyc();
            if (obs_acc0) req0_valid = 0;
        end
        wait_idle();
        if (rlog.size() >= n + 2) begin
            chk("bp_id", rlog[n].id, 1);
            chk("bp_total", rlog[n].total, 14);
            chk("bp_ov", rlog[n].ov, 1);
            chk("bp_next_total", rlog[n+1].total, 5);
        end else begin
            chk("bp_cnt", rlog.size(), n + 2);
        end

        // Reset during EXEC discards the operation
        send(0, 6, 6, 0);
        chk("midop_busy", busy, 1);
        do_reset();
        n = rlog.size();
        for (int i = 0; i < 3; i++) cyc();
        chk("midop_no_rsp", rlog.size(), n);
        send(1, 3, 2, 0);
        wait_idle();
        chk("midop_cnt", rlog.size(), n + 1);
        if (rlog.size() > n) begin
            chk("midop_id", rlog[n].id, 1);
            chk("midop_total", rlog[n].total, 5);
        end

        // Randomised traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_s = 1'($urandom);
            end else if (req0_valid && $urandom_range(0, 15) == 0) begin
                req0_valid = 0;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_s = 1'($urandom);
            end else if (req1_valid && $urandom_range(0, 15) == 0) begin
                req1_valid = 0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
            ov_clr = ($urandom_range(0, 15) == 0);
`endif
            cyc();
            if (obs_acc0) req0_valid = 0;
            if (obs_acc1) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
`ifdef ADD_SUB_ARBITER_OV_CNT_EN
        ov_clr = 0;
`endif
        wait_idle();

`ifdef ADD_SUB_ARBITER_OV_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(0, 5, 4, 0);
            wait_idle();
        end
        chk("ov_count_three", ov_count, 3);
        send(0, 5, 4, 0);
        ov_clr = 1;
        cyc();
        ov_clr = 0;
        chk("ov_clr_priority", ov_count, 0);
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
